div: RTL and testbench
======================

# div

Sequential restoring divider: the inverse of the shift-add multiplier. It divides an NW-bit dividend by a DW-bit divisor and produces one quotient bit per clock, MSB first. It uses the same `start`/`fin` handshake as the multiplier, so a controller drives both blocks identically. A product from the multiplier can be divided by one operand to recover the other.

## Interface

- `NW`, default 16: dividend and quotient width.
- `DW`, default 8: divisor and remainder width.
- `ck`, input, 1: clock. All state changes on the posedge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: load request, level-sampled on each posedge of `ck`.
- `N`, input, NW: dividend, captured while `start` is 1.
- `D`, input, DW: divisor, captured while `start` is 1.
- `Q`, output, NW: quotient. Equals the result while `fin`=1, otherwise 0.
- `R`, output, DW: remainder. Equals the result while `fin`=1, otherwise 0.
- `fin`, output, 1: one-cycle result-valid pulse.
- `dz`, output, 1: divide-by-zero flag. Meaningful only while `fin`=1, otherwise 0.
- `busy`, input/output: `busy` is an output, 1 bit, high from load through the `fin` cycle.

## Operation

- States:
  - IDLE.
  - RUN: iteration counter `k`, 0..NW-1.
  - DONE: the `fin` cycle.
- Reset (`rst`=1, asynchronous, at any time):
  - State goes to IDLE.
  - `fin`, `dz` and `busy` are 0.
  - Internal quotient, remainder and counter are cleared.
  - `Q` and `R` read 0.
- Load: on any posedge with `start`=1, in any state:
  - Capture `N` and `D`, clear the partial remainder `rem` (DW+1 bits), clear the quotient register and `k`.
  - Set `dz` = (`D`==0) internally, go to RUN, force `fin`=0.
  - `start` has priority over iteration and over DONE.
- RUN iteration (posedge, `start`=0):
  - Compute t = {rem[DW-1:0], Nreg[NW-1-k]}.
  - If t >= Dreg: rem <= t - Dreg and quotient bit NW-1-k <= 1.
  - Otherwise: rem <= t and the quotient bit <= 0.
  - `k` increments.
  - At k = NW-1, the final bit is written and the state moves to DONE in the same edge.
- Width rule: t is DW+1 bits. Comparison and subtraction are unsigned at DW+1 bits. After each step rem < Dreg, so `R` fits in DW bits.
- Divide by zero: iterations still run, for constant latency. On the final edge the results are forced to `Q` = all ones, `R` = 0, `dz`=1.
- DONE: `fin`=1 for exactly one cycle. On the next posedge with `start`=0 the state goes to IDLE and `fin`=0.
- IDLE holds with all outputs 0 until `start`.
- The result is not retained after `fin`. The consumer must sample `Q`, `R` and `dz` during the `fin` cycle.

## Timing

- Let E0 be the first posedge at which `start`=0 after a load.
- Iterations occur at edges E0 .. E(NW-1).
- `fin`, `Q`, `R` and `dz` become valid after E(NW-1) and clear after E(NW).
- Latency is NW cycles from `start` falling to `fin`, which is 16 with default parameters. It is independent of operand values.
- `start` held high keeps reloading: no progress is made and `fin` stays 0.
- `start`=1 during RUN aborts the operation and restarts with the new operands. No `fin` is produced for the aborted operation.
- `start`=1 during the DONE cycle: `fin` is still visible in that cycle, and the next edge loads the new operands.
- `busy` is 1 from the load edge through the DONE cycle and 0 in IDLE.

## Structure

- Shared package `div_pkg`:
  - State encoding constants ST_IDLE, ST_RUN, ST_DONE.
  - Default widths NW_DEF=16, DW_DEF=8.
  - Counter width function clog2(NW).
- Sub-module `div_step`: combinational, with parameter DW.
  - Inputs: rem, the next dividend bit, the divisor.
  - Outputs: next rem and the quotient bit.
- `div` instantiates one `div_step` and holds all state registers.

## Test plan

- N=100, D=7: after `start` pulse and release, `fin`=1 on the 16th edge with `Q`=14, `R`=2, `dz`=0. `Q` and `R` read 0 on every other cycle.
- N=65535, D=255: expect `Q`=257, `R`=0. Then N=5, D=9: expect `Q`=0, `R`=5.
- Inverse check: N=24600 (the multiplier result for 200*123), D=123: expect `Q`=200, `R`=0.
- N=1234, D=0: `fin` at the 16th edge with `dz`=1, `Q`=16'hFFFF, `R`=0.
- Restart: `start` at cycle 5 of the run with N=50, D=5. There is no `fin` for the first operation. `fin` arrives 16 edges after the second `start` falls, with `Q`=10, `R`=0.
- Async reset: assert `rst` mid-cycle during RUN k=8. `fin`, `busy`, `Q` and `R` go to 0 immediately. After release, IDLE holds with no `fin` until the next `start`.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default widths and the iteration-counter width helper.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NW_DEF = 16;
    localparam int DW_DEF = 8;

    // Never returns 0 so the counter always has at least one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
// Purely combinational.
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] rem_i,
    input  logic          n_bit_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] rem_o,
    output logic          q_bit_o
);

    logic [DW:0] t;

    assign t       = {rem_i, n_bit_i};
    assign q_bit_o = (t >= {1'b0, d_i});
    // t - d < d whenever it fits, so the difference is exact in the low DW bits.
    assign rem_o   = t[DW-1:0] - (q_bit_o ? d_i : '0);

endmodule

// File: rtl/div.sv
// Sequential restoring divider, one quotient bit per clock, MSB first; start reloads at any time.
// Result valid on the single fin cycle, NW edges after start falls; no backpressure.
module div
    import div_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] N,
    input  logic [DW-1:0] D,
    output logic [NW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          fin,
    output logic          dz,
    output logic          busy
);

    localparam int          KW     = clog2(NW);
    localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [NW-1:0] nreg_q, nreg_d;
    logic [DW-1:0] dreg_q, dreg_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [NW-1:0] quo_q, quo_d;
    logic          dz_q, dz_d;

    logic [DW-1:0] rem_nxt;
    logic          q_bit;

    div_step #(.DW(DW)) u_step (
        .rem_i   (rem_q),
        .n_bit_i (nreg_q[NW-1]),
        .d_i     (dreg_q),
        .rem_o   (rem_nxt),
        .q_bit_o (q_bit)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (k_q == K_LAST) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        fin  = (state_q == ST_DONE);
        busy = (state_q != ST_IDLE);
        Q    = fin ? quo_q : '0;
        R    = fin ? rem_q : '0;
        dz   = fin & dz_q;
    end

    // The dividend is shifted out MSB first and the quotient shifted in LSB,
    // so after NW steps the first quotient bit has reached the MSB.
    always_comb begin
        k_d    = k_q;
        nreg_d = nreg_q;
        dreg_d = dreg_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dz_d   = dz_q;
        if (start) begin
            k_d    = '0;
            nreg_d = N;
            dreg_d = D;
            rem_d  = '0;
            quo_d  = '0;
            dz_d   = (D == '0);
        end else if (state_q == ST_RUN) begin
            k_d    = k_q + KW'(1);
            nreg_d = nreg_q << 1;
            rem_d  = rem_nxt;
            quo_d  = {quo_q[NW-2:0], q_bit};
            if ((k_q == K_LAST) && dz_q) begin
                quo_d = '1;
                rem_d = '0;
            end
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            nreg_q <= '0;
            dreg_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            k_q    <= k_d;
            nreg_q <= nreg_d;
            dreg_q <= dreg_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed cases plus random operands against an arithmetic model.
module tb_div;

    localparam int NW = 16;
    localparam int DW = 8;

    logic          ck;
    logic          rst;
    logic          start;
    logic [NW-1:0] N;
    logic [DW-1:0] D;
    logic [NW-1:0] Q;
    logic [DW-1:0] R;
    logic          fin;
    logic          dz;
    logic          busy;

    int n_checks;
    int n_errors;

    div #(.NW(NW), .DW(DW)) dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .fin   (fin),
        .dz    (dz),
        .busy  (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, divide-by-zero yields all-ones / 0 / flag.
    task automatic model(input logic [NW-1:0] n, input logic [DW-1:0] d,
                         output logic [NW-1:0] eq, output logic [DW-1:0] er, output logic ez);
        if (d == 0) begin
            eq = {NW{1'b1}};
            er = '0;
            ez = 1'b1;
        end else begin
            eq = NW'(32'(n) / 32'(d));
            er = DW'(32'(n) % 32'(d));
            ez = 1'b0;
        end
    endtask

    // Pulse start for one edge; inputs change 1 time unit after the edge.
    task automatic load(input logic [NW-1:0] n, input logic [DW-1:0] d);
        start = 1'b1;
        N     = n;
        D     = d;
        @(posedge ck);
        #1;
        start = 1'b0;
        N     = $urandom;
        D     = $urandom;
    endtask

    task automatic quiet_edges(input int cnt, input string tag);
        for (int i = 0; i < cnt; i++) begin
            @(posedge ck);
            #1;
            check(tag, {fin, dz, Q, R}, 64'd0);
        end
    endtask

    task automatic check_result(input logic [NW-1:0] n, input logic [DW-1:0] d);
        logic [NW-1:0] eq;
        logic [DW-1:0] er;
        logic          ez;
        model(n, d, eq, er, ez);
        check("fin", {63'd0, fin}, 64'd1);
        check("busy_done", {63'd0, busy}, 64'd1);
        check("Q", {48'd0, Q}, {48'd0, eq});
        check("R", {56'd0, R}, {56'd0, er});
        check("dz", {63'd0, dz}, {63'd0, ez});
    endtask

    // Full operation: load, NW-1 quiet edges, result on edge NW, cleared after.
    task automatic run_op(input logic [NW-1:0] n, input logic [DW-1:0] d);
        load(n, d);
        quiet_edges(NW - 1, "quiet");
        @(posedge ck);
        #1;
        check_result(n, d);
        @(posedge ck);
        #1;
        check("after_fin", {fin, busy, dz, Q, R}, 64'd0);
    endtask

    initial begin
        logic [NW-1:0] rn;
        logic [DW-1:0] rd;
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        N     = '0;
        D     = '0;
        #3;
        check("reset_out", {fin, busy, dz, Q, R}, 64'd0);
        @(negedge ck);
        rst = 1'b0;
        @(posedge ck);
        #1;
        check("idle_out", {fin, busy, dz, Q, R}, 64'd0);

        run_op(16'd100, 8'd7);
        run_op(16'd65535, 8'd255);
        run_op(16'd5, 8'd9);
        run_op(16'd24600, 8'd123);
        run_op(16'd1234, 8'd0);
        run_op(16'd0, 8'd1);
        run_op(16'd255, 8'd1);

        // Restart mid-run: first operation must never report.
        load(16'd1234, 8'd3);
        quiet_edges(5, "pre_abort");
        check("busy_run", {63'd0, busy}, 64'd1);
        run_op(16'd50, 8'd5);

        // start held high keeps reloading without progress.
        start = 1'b1;
        N     = 16'd999;
        D     = 8'd10;
        for (int i = 0; i < 20; i++) begin
            @(posedge ck);
            #1;
            check("held_fin", {63'd0, fin}, 64'd0);
        end
        check("held_busy", {63'd0, busy}, 64'd1);
        start = 1'b0;
        quiet_edges(NW - 1, "held_quiet");
        @(posedge ck);
        #1;
        check_result(16'd999, 8'd10);
        @(posedge ck);
        #1;

        // start during the fin cycle: fin stays visible, then the new operands run.
        load(16'd4000, 8'd33);
        quiet_edges(NW - 1, "chain_quiet");
        @(posedge ck);
        #1;
        start = 1'b1;
        N     = 16'd777;
        D     = 8'd7;
        #1;
        check_result(16'd4000, 8'd33);
        @(posedge ck);
        #1;
        start = 1'b0;
        quiet_edges(NW - 1, "chain2_quiet");
        @(posedge ck);
        #1;
        check_result(16'd777, 8'd7);
        @(posedge ck);
        #1;

        // Async reset in the middle of a run at k=8.
        load(16'd60000, 8'd77);
        quiet_edges(8, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {fin, busy, dz, Q, R}, 64'd0);
        @(negedge ck);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge ck);
            #1;
            check("post_rst", {fin, busy, dz, Q, R}, 64'd0);
        end

        for (int j = 0; j < 40; j++) begin
            rn = NW'($urandom);
            case ($urandom_range(0, 3))
                0:       rd = '0;
                1:       rd = DW'($urandom_range(1, 4));
                default: rd = DW'($urandom_range(1, 255));
            endcase
            run_op(rn, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
